// File: rtl/memc3_seq_pkg.sv
// Shared types and helpers for the MEMC3 ready sequencer: FSM states, fault codes
// and counter sizing.
package memc3_seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET      = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_WAIT_CALIB = 3'd2,
      ST_SETTLE     = 3'd3,
      ST_READY      = 3'd4,
      ST_SOFT_RST   = 3'd5,
      ST_DEAD       = 3'd6
   } seq_state_e;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_TIMEOUT = 2'd1;
   localparam logic [1:0] FC_LOCK    = 2'd2;
   localparam logic [1:0] FC_CALIB   = 2'd3;

   // Bits needed to hold 0..maxv.
   function automatic int cnt_w(input int maxv);
      return (maxv < 2) ? 1 : $clog2(maxv + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/memc3_sync2.sv
// Two-flop synchroniser into the clk0_bufg domain, clears to 0 on sys_rst.
module memc3_sync2 (
   input  logic clk0_bufg,
   input  logic sys_rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk0_bufg or posedge sys_rst) begin
      if (sys_rst) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], d_i};
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/memc3_ready_sequencer.sv
// Application reset / ready sequencer with fault detection and bounded soft-reset retries.
// Optional status counters (lock_loss_cnt, calib_cycles) are built when MEMC3_SEQ_STATUS_EN is defined.
module memc3_ready_sequencer
   import memc3_seq_pkg::*;
#(
   parameter int CALIB_TIMEOUT   = 1048576,
   parameter int LOCK_DEBOUNCE   = 16,
   parameter int RDY_DELAY       = 8,
   parameter int SOFT_RST_CYCLES = 32,
   parameter int MAX_RETRIES     = 3
) (
   input  logic        clk0_bufg,
   input  logic        sys_rst,
   input  logic        rst0,
   input  logic        pll_lock,
   input  logic        calib_done,
   output logic        app_rst,
   output logic        app_ready,
   output logic        mcb_soft_rst,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [3:0]  retry_cnt,
   output logic [7:0]  lock_loss_cnt,
   output logic [19:0] calib_cycles
);

   localparam int CNT_W = cnt_w(max3(CALIB_TIMEOUT, RDY_DELAY, SOFT_RST_CYCLES));
   localparam int DBC_W = cnt_w(LOCK_DEBOUNCE);
   localparam logic [CNT_W-1:0] TMO       = CNT_W'(CALIB_TIMEOUT);
   localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(RDY_DELAY - 1);
   localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SOFT_RST_CYCLES - 1);
   localparam logic [DBC_W-1:0] DBC_MAX   = DBC_W'(LOCK_DEBOUNCE);
   localparam logic [3:0]       MAX_R     = 4'(MAX_RETRIES);

   logic lock_s, calib_s;

   memc3_sync2 u_sync_lock  (.clk0_bufg(clk0_bufg), .sys_rst(sys_rst), .d_i(pll_lock),   .q_o(lock_s));
   memc3_sync2 u_sync_calib (.clk0_bufg(clk0_bufg), .sys_rst(sys_rst), .d_i(calib_done), .q_o(calib_s));

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DBC_W-1:0] dbc_q, dbc_d;
   logic [1:0]       fc_q, fc_d;
   logic [3:0]       retry_q, retry_d;
   logic             app_rst_q, app_ready_q, soft_q, fault_q;
   logic             fault_take;
   logic [1:0]       fault_cause;

   always_comb begin
      state_d     = state_q;
      fc_d        = fc_q;
      retry_d     = retry_q;
      fault_take  = 1'b0;
      fault_cause = FC_NONE;
      case (state_q)
         ST_RESET:      if (!rst0) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK:  if (lock_s) state_d = ST_WAIT_CALIB;
         ST_WAIT_CALIB: begin
            // Timeout wins over a calibration that completes on the same cycle.
            if (cnt_q == TMO) begin
               fault_take  = 1'b1;
               fault_cause = FC_TIMEOUT;
            end else if (calib_s) state_d = ST_SETTLE;
         end
         ST_SETTLE:     if (cnt_q == RDY_LAST) state_d = ST_SETTLE == state_q ? ST_READY : state_q;
         ST_READY: begin
            if (dbc_q == DBC_MAX) begin
               fault_take  = 1'b1;
               fault_cause = FC_LOCK;
            end else if (!calib_s) begin
               fault_take  = 1'b1;
               fault_cause = FC_CALIB;
            end
         end
         ST_SOFT_RST:   if (cnt_q == SRST_LAST) state_d = ST_WAIT_LOCK;
         ST_DEAD:       state_d = ST_DEAD;
         default:       state_d = ST_RESET;
      endcase
      if (fault_take) begin
         fc_d = fault_cause;
         if (retry_q < MAX_R) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_SOFT_RST;
         end else begin
            state_d = ST_DEAD;
         end
      end
      // Controller reset overrides everything except a dead block; history is kept.
      if (rst0 && state_q != ST_DEAD) begin
         state_d = ST_RESET;
         fc_d    = fc_q;
         retry_d = retry_q;
      end
   end

   // One phase counter serves timeout, settle and soft-reset timing; it restarts on every state change.
   assign cnt_d = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
   assign dbc_d = (state_q == ST_READY && !lock_s) ?
                  ((dbc_q == DBC_MAX) ? dbc_q : dbc_q + 1'b1) : '0;

   always_ff @(posedge clk0_bufg or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_RESET;
         cnt_q       <= '0;
         dbc_q       <= '0;
         fc_q        <= FC_NONE;
         retry_q     <= 4'd0;
         app_rst_q   <= 1'b1;
         app_ready_q <= 1'b0;
         soft_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dbc_q       <= dbc_d;
         fc_q        <= fc_d;
         retry_q     <= retry_d;
         app_rst_q   <= (state_d != ST_READY);
         app_ready_q <= (state_d == ST_READY);
         soft_q      <= (state_d == ST_SOFT_RST);
         fault_q     <= (state_d == ST_DEAD);
      end
   end

   assign app_rst      = app_rst_q;
   assign app_ready    = app_ready_q;
   assign mcb_soft_rst = soft_q;
   assign fault        = fault_q;
   assign fault_code   = fc_q;
   assign retry_cnt    = retry_q;

`ifdef MEMC3_SEQ_STATUS_EN
   logic [7:0]  llc_q;
   logic [19:0] ccy_q;
   logic        lock_evt;

   assign lock_evt = (state_q == ST_READY) && (dbc_q == DBC_MAX) && !rst0;

   always_ff @(posedge clk0_bufg or posedge sys_rst) begin
      if (sys_rst) begin
         llc_q <= 8'd0;
         ccy_q <= 20'd0;
      end else begin
         if (lock_evt && llc_q != 8'hFF) llc_q <= llc_q + 8'd1;
         if (state_q == ST_WAIT_CALIB && state_d == ST_SETTLE) ccy_q <= 20'(cnt_q);
      end
   end

   assign lock_loss_cnt = llc_q;
   assign calib_cycles  = ccy_q;
`else
   assign lock_loss_cnt = 8'd0;
   assign calib_cycles  = 20'd0;
`endif

endmodule
